// File: rtl/miriscv_lsu_hs_pkg.sv
`default_nettype none
// ============================================================================
// Module  : miriscv_lsu_hs_pkg
// Brief   : Load/store size codes, LSU state encoding and small helpers
//           shared by the handshaked LSU and its lane logic.
// Revision: 1.0 - initial release
// ============================================================================
package miriscv_lsu_hs_pkg;

  // Access size codes (funct3 encoding of RISC-V loads/stores)
  localparam logic [2:0] LDST_B  = 3'b000;
  localparam logic [2:0] LDST_H  = 3'b001;
  localparam logic [2:0] LDST_W  = 3'b010;
  localparam logic [2:0] LDST_BU = 3'b100;
  localparam logic [2:0] LDST_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  // Size codes 3'b011, 3'b110 and 3'b111 have no meaning for this LSU
  function automatic logic size_legal(input logic [2:0] size);
    case (size)
      LDST_B, LDST_H, LDST_W, LDST_BU, LDST_HU: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

  // Offset actually used inside the word: bits below the access size dropped
  function automatic logic [1:0] align_off(input logic [2:0] size, input logic [1:0] off);
    case (size)
      LDST_H, LDST_HU: return {off[1], 1'b0};
      LDST_W:          return 2'b00;
      default:         return off;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] off);
    case (size)
      LDST_H, LDST_HU: return off[0];
      LDST_W:          return (off != 2'b00);
      default:         return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/miriscv_lsu_hs_if.sv
`default_nettype none
// ============================================================================
// Module  : miriscv_lsu_hs_core_if / miriscv_lsu_hs_mem_if
// Brief   : Core-to-LSU request/stall interface and LSU-to-memory
//           req/gnt/rvalid bus interface.
// Revision: 1.0 - initial release
// ============================================================================
interface miriscv_lsu_hs_core_if #(
  parameter int ADDR_W = 32
);
  logic              lsu_req;
  logic              lsu_we;
  logic [2:0]        lsu_size;
  logic [ADDR_W-1:0] lsu_addr;
  logic [31:0]       lsu_wdata;
  logic [31:0]       lsu_data;
  logic              lsu_err;
  logic              lsu_misalign;
  logic              core_stall;

  // The core issues requests
  modport master (
    output lsu_req, lsu_we, lsu_size, lsu_addr, lsu_wdata,
    input  lsu_data, lsu_err, lsu_misalign, core_stall
  );

  // The LSU serves them
  modport slave (
    input  lsu_req, lsu_we, lsu_size, lsu_addr, lsu_wdata,
    output lsu_data, lsu_err, lsu_misalign, core_stall
  );
endinterface

interface miriscv_lsu_hs_mem_if #(
  parameter int ADDR_W = 32
);
  logic              data_req;
  logic              data_gnt;
  logic              data_we;
  logic [3:0]        data_be;
  logic [ADDR_W-1:0] data_addr;
  logic [31:0]       data_wdata;
  logic              data_rvalid;
  logic [31:0]       data_rdata;

  // The LSU drives the bus
  modport master (
    output data_req, data_we, data_be, data_addr, data_wdata,
    input  data_gnt, data_rvalid, data_rdata
  );

  // The data memory answers
  modport slave (
    input  data_req, data_we, data_be, data_addr, data_wdata,
    output data_gnt, data_rvalid, data_rdata
  );
endinterface
`default_nettype wire

// File: rtl/miriscv_lsu_hs_lanes.sv
`default_nettype none
// ============================================================================
// Module  : miriscv_lsu_hs_lanes
// Brief   : Combinational byte-enable / store-data replication for requests
//           and lane select with sign/zero extension for load responses.
// Revision: 1.0 - initial release
// ============================================================================
module miriscv_lsu_hs_lanes
  import miriscv_lsu_hs_pkg::*;
(
  input  logic [2:0]  req_size,
  input  logic [1:0]  req_off,
  input  logic        req_we,
  input  logic [31:0] req_wdata,
  output logic [3:0]  req_be,
  output logic [31:0] req_wdata_rep,
  input  logic [2:0]  rsp_size,
  input  logic [1:0]  rsp_off,
  input  logic [31:0] rsp_rdata,
  output logic [31:0] rsp_data
);

  logic [7:0]  rsp_byte;
  logic [15:0] rsp_half;

  // Request side: stores enable only their lanes, loads always read a full word
  always_comb begin
    req_be        = 4'b1111;
    req_wdata_rep = req_wdata;
    case (req_size)
      LDST_B, LDST_BU: begin
        req_be        = 4'b0001 << req_off;
        req_wdata_rep = {4{req_wdata[7:0]}};
      end
      LDST_H, LDST_HU: begin
        req_be        = req_off[1] ? 4'b1100 : 4'b0011;
        req_wdata_rep = {2{req_wdata[15:0]}};
      end
      default: begin
        req_be        = 4'b1111;
        req_wdata_rep = req_wdata;
      end
    endcase
    if (!req_we) req_be = 4'b1111;
  end

  // Response side: pick the addressed lane and extend it to 32 bits
  always_comb begin
    case (rsp_off)
      2'd0:    rsp_byte = rsp_rdata[7:0];
      2'd1:    rsp_byte = rsp_rdata[15:8];
      2'd2:    rsp_byte = rsp_rdata[23:16];
      default: rsp_byte = rsp_rdata[31:24];
    endcase
    rsp_half = rsp_off[1] ? rsp_rdata[31:16] : rsp_rdata[15:0];
    case (rsp_size)
      LDST_B:  rsp_data = {{24{rsp_byte[7]}}, rsp_byte};
      LDST_BU: rsp_data = {24'd0, rsp_byte};
      LDST_H:  rsp_data = {{16{rsp_half[15]}}, rsp_half};
      LDST_HU: rsp_data = {16'd0, rsp_half};
      default: rsp_data = rsp_rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/miriscv_lsu_hs.sv
`default_nettype none
// ============================================================================
// Module  : miriscv_lsu_hs
// Brief   : Handshaked multi-cycle load/store unit. Latches one core request,
//           runs a req/gnt/rvalid memory transaction, stalls the core until
//           the result is ready, with bus timeout and illegal-size errors.
//           Optional macro LSU_MISALIGN_TRAP_EN: misaligned H/W accesses are
//           reported on lsu_misalign instead of being forced aligned.
// Revision: 1.0 - initial release
// ============================================================================
module miriscv_lsu_hs
  import miriscv_lsu_hs_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  miriscv_lsu_hs_core_if.slave  core,
  miriscv_lsu_hs_mem_if.master  mem
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_REQ  = REQ;
  localparam logic [1:0] ST_WAIT = WAIT;
  localparam logic [1:0] ST_DONE = DONE;

  // Counter holds cycles already spent in REQ/WAIT; last legal value is TIMEOUT_CYC-1
  localparam int              CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        acc_size;
  logic [1:0]        acc_off;
  logic [31:0]       data_q;
  logic              err_q;
  logic              misalign_q;
  logic              req_q;
  logic              we_q;
  logic [3:0]        be_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic [1:0]        off_eff;
  logic              misalign;
  logic              timeout;
  logic [3:0]        be_new;
  logic [31:0]       wdata_new;
  logic [31:0]       load_data;

  assign off_eff = align_off(core.lsu_size, core.lsu_addr[1:0]);

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = is_misaligned(core.lsu_size, core.lsu_addr[1:0]);
`else
  assign misalign = 1'b0;
`endif

  assign timeout = (TIMEOUT_CYC > 0) && (cnt == CNT_LAST);

  miriscv_lsu_hs_lanes u_lanes (
    .req_size      (core.lsu_size),
    .req_off       (off_eff),
    .req_we        (core.lsu_we),
    .req_wdata     (core.lsu_wdata),
    .req_be        (be_new),
    .req_wdata_rep (wdata_new),
    .rsp_size      (acc_size),
    .rsp_off       (acc_off),
    .rsp_rdata     (mem.data_rdata),
    .rsp_data      (load_data)
  );

  // Transaction FSM with its registered bus and result outputs
  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      acc_size   <= LDST_W;
      acc_off    <= 2'b00;
      data_q     <= 32'd0;
      err_q      <= 1'b0;
      misalign_q <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      be_q       <= 4'd0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (core.lsu_req) begin
            err_q      <= 1'b0;
            misalign_q <= 1'b0;
            acc_size   <= core.lsu_size;
            acc_off    <= off_eff;
            we_q       <= core.lsu_we;
            be_q       <= be_new;
            addr_q     <= {core.lsu_addr[ADDR_W-1:2], 2'b00};
            wdata_q    <= wdata_new;
            if (!size_legal(core.lsu_size)) begin
              err_q <= 1'b1;
              state <= ST_DONE;
            end else if (misalign) begin
              misalign_q <= 1'b1;
              state      <= ST_DONE;
            end else begin
              req_q <= 1'b1;
              state <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          cnt <= cnt + CNT_W'(1);
          if (timeout) begin
            req_q  <= 1'b0;
            err_q  <= 1'b1;
            data_q <= 32'd0;
            state  <= ST_DONE;
          end else if (mem.data_gnt) begin
            req_q <= 1'b0;
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt <= cnt + CNT_W'(1);
          // A response on the last allowed cycle still completes normally
          if (mem.data_rvalid) begin
            if (!we_q) data_q <= load_data;
            state <= ST_DONE;
          end else if (timeout) begin
            err_q  <= 1'b1;
            data_q <= 32'd0;
            state  <= ST_DONE;
          end
        end
        default: begin
          cnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign core.core_stall   = core.lsu_req & (state != ST_DONE);
  assign core.lsu_data     = data_q;
  assign core.lsu_err      = err_q;
  assign core.lsu_misalign = misalign_q;

  assign mem.data_req   = req_q;
  assign mem.data_we    = we_q;
  assign mem.data_be    = be_q;
  assign mem.data_addr  = addr_q;
  assign mem.data_wdata = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_miriscv_lsu_hs.sv
`default_nettype none
// ============================================================================
// Module  : tb_miriscv_lsu_hs
// Brief   : Self-checking bench for miriscv_lsu_hs: table of single
//           transactions plus hand-written wait-state, timeout and
//           mid-transaction reset sequences.
// Revision: 1.0 - initial release
// ============================================================================
module tb_miriscv_lsu_hs;
  import miriscv_lsu_hs_pkg::*;

  logic clk = 1'b0;
  logic arstn;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  miriscv_lsu_hs_core_if #(.ADDR_W(32)) core_bus ();
  miriscv_lsu_hs_mem_if  #(.ADDR_W(32)) mem_bus ();

  miriscv_lsu_hs #(.ADDR_W(32), .TIMEOUT_CYC(8)) dut (
    .clk_i   (clk),
    .arstn_i (arstn),
    .core    (core_bus),
    .mem     (mem_bus)
  );

  typedef struct {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        exp_req;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_data;
    logic        exp_err;
    logic        exp_mis;
    int          exp_stall;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One core access with a simple memory responder; gnt after gnt_dly REQ cycles
  task automatic run_txn(input logic we, input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int gnt_dly, input logic give_rvalid,
                         output int stall_n, output int req_n, output logic stable,
                         output logic [3:0] be_o, output logic [31:0] addr_o,
                         output logic [31:0] wdata_o, output logic [31:0] data_o,
                         output logic err_o, output logic mis_o, output logic req_done,
                         output logic timed_out);
    logic granted;
    logic we_o;
    @(posedge clk); #1;
    core_bus.lsu_req   = 1'b1;
    core_bus.lsu_we    = we;
    core_bus.lsu_size  = size;
    core_bus.lsu_addr  = addr;
    core_bus.lsu_wdata = wdata;
    stall_n = 0; req_n = 0; stable = 1'b1; timed_out = 1'b1; granted = 1'b0;
    be_o = 4'd0; addr_o = 32'd0; wdata_o = 32'd0; we_o = 1'b0;
    data_o = 32'd0; err_o = 1'b0; mis_o = 1'b0; req_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      mem_bus.data_gnt    = 1'b0;
      mem_bus.data_rvalid = 1'b0;
      if (!core_bus.core_stall) begin
        data_o    = core_bus.lsu_data;
        err_o     = core_bus.lsu_err;
        mis_o     = core_bus.lsu_misalign;
        req_done  = mem_bus.data_req;
        timed_out = 1'b0;
        break;
      end
      stall_n++;
      if (mem_bus.data_req) begin
        if (req_n == 0) begin
          be_o = mem_bus.data_be; addr_o = mem_bus.data_addr;
          wdata_o = mem_bus.data_wdata; we_o = mem_bus.data_we;
        end else if (be_o !== mem_bus.data_be || addr_o !== mem_bus.data_addr ||
                     wdata_o !== mem_bus.data_wdata || we_o !== mem_bus.data_we) begin
          stable = 1'b0;
        end
        if (req_n == gnt_dly) begin
          mem_bus.data_gnt = 1'b1;
          granted = 1'b1;
        end
        req_n++;
      end else if (granted && give_rvalid) begin
        mem_bus.data_rvalid = 1'b1;
        mem_bus.data_rdata  = rdata;
      end
    end
    core_bus.lsu_req    = 1'b0;
    mem_bus.data_gnt    = 1'b0;
    mem_bus.data_rvalid = 1'b0;
    @(posedge clk);
  endtask

  int          stall_n, req_n;
  logic        stable, err_o, mis_o, req_done, timed_out;
  logic [3:0]  be_o;
  logic [31:0] addr_o, wdata_o, data_o;

  initial begin
    // we size addr wdata rdata | req be addr wdata data err mis stall
    vecs[0]  = '{1'b0, LDST_W,  32'h100, 32'h0,        32'hDEADBEEF, 1'b1, 4'b1111, 32'h100, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 3};
    vecs[1]  = '{1'b0, LDST_B,  32'h103, 32'h0,        32'h80112233, 1'b1, 4'b1111, 32'h100, 32'h0,        32'hFFFFFF80, 1'b0, 1'b0, 3};
    vecs[2]  = '{1'b0, LDST_BU, 32'h103, 32'h0,        32'h80112233, 1'b1, 4'b1111, 32'h100, 32'h0,        32'h00000080, 1'b0, 1'b0, 3};
    vecs[3]  = '{1'b0, LDST_HU, 32'h102, 32'h0,        32'h80112233, 1'b1, 4'b1111, 32'h100, 32'h0,        32'h00008011, 1'b0, 1'b0, 3};
    vecs[4]  = '{1'b0, LDST_H,  32'h102, 32'h0,        32'h80112233, 1'b1, 4'b1111, 32'h100, 32'h0,        32'hFFFF8011, 1'b0, 1'b0, 3};
    vecs[5]  = '{1'b0, LDST_B,  32'h100, 32'h0,        32'h80112233, 1'b1, 4'b1111, 32'h100, 32'h0,        32'h00000033, 1'b0, 1'b0, 3};
    vecs[6]  = '{1'b1, LDST_B,  32'h101, 32'h123456A5, 32'hFFFFFFFF, 1'b1, 4'b0010, 32'h100, 32'hA5A5A5A5, 32'h00000033, 1'b0, 1'b0, 3};
    vecs[7]  = '{1'b1, LDST_H,  32'h102, 32'hABCD1234, 32'hFFFFFFFF, 1'b1, 4'b1100, 32'h100, 32'h12341234, 32'h00000033, 1'b0, 1'b0, 3};
    vecs[8]  = '{1'b1, LDST_W,  32'h204, 32'hCAFEF00D, 32'hFFFFFFFF, 1'b1, 4'b1111, 32'h204, 32'hCAFEF00D, 32'h00000033, 1'b0, 1'b0, 3};
    vecs[9]  = '{1'b0, LDST_H,  32'h200, 32'h0,        32'h00007FFF, 1'b1, 4'b1111, 32'h200, 32'h0,        32'h00007FFF, 1'b0, 1'b0, 3};
    vecs[10] = '{1'b0, 3'b011,  32'h300, 32'h0,        32'h11111111, 1'b0, 4'b1111, 32'h300, 32'h0,        32'h00007FFF, 1'b1, 1'b0, 1};
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[11] = '{1'b0, LDST_W,  32'h101, 32'h0,        32'h11223344, 1'b0, 4'b1111, 32'h100, 32'h0,        32'h00007FFF, 1'b0, 1'b1, 1};
    vecs[12] = '{1'b0, LDST_HU, 32'h103, 32'h0,        32'hAABBCCDD, 1'b0, 4'b1111, 32'h100, 32'h0,        32'h00007FFF, 1'b0, 1'b1, 1};
`else
    vecs[11] = '{1'b0, LDST_W,  32'h101, 32'h0,        32'h11223344, 1'b1, 4'b1111, 32'h100, 32'h0,        32'h11223344, 1'b0, 1'b0, 3};
    vecs[12] = '{1'b0, LDST_HU, 32'h103, 32'h0,        32'hAABBCCDD, 1'b1, 4'b1111, 32'h100, 32'h0,        32'h0000AABB, 1'b0, 1'b0, 3};
`endif
    vecs[13] = '{1'b0, LDST_B,  32'h101, 32'h0,        32'h0000FE00, 1'b1, 4'b1111, 32'h100, 32'h0,        32'hFFFFFFFE, 1'b0, 1'b0, 3};

    arstn               = 1'b0;
    core_bus.lsu_req    = 1'b1;
    core_bus.lsu_we     = 1'b0;
    core_bus.lsu_size   = LDST_W;
    core_bus.lsu_addr   = 32'h0;
    core_bus.lsu_wdata  = 32'h0;
    mem_bus.data_gnt    = 1'b0;
    mem_bus.data_rvalid = 1'b0;
    mem_bus.data_rdata  = 32'h0;

    // Reset state, with a request pending so stall must follow lsu_req
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall_req_high", 32'(core_bus.core_stall), 32'd1);
    check("rst_data_req", 32'(mem_bus.data_req), 32'd0);
    core_bus.lsu_req = 1'b0;
    @(negedge clk);
    arstn = 1'b1;
    check("rst_stall", 32'(core_bus.core_stall), 32'd0);
    check("rst_lsu_data", core_bus.lsu_data, 32'd0);
    check("rst_err", 32'(core_bus.lsu_err), 32'd0);
    check("rst_misalign", 32'(core_bus.lsu_misalign), 32'd0);
    check("rst_we", 32'(mem_bus.data_we), 32'd0);
    check("rst_be", 32'(mem_bus.data_be), 32'd0);
    check("rst_addr", mem_bus.data_addr, 32'd0);
    check("rst_wdata", mem_bus.data_wdata, 32'd0);

    // Table of single transactions, grant at once and response next cycle
    for (int i = 0; i < 14; i++) begin
      run_txn(vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, 0, 1'b1,
              stall_n, req_n, stable, be_o, addr_o, wdata_o, data_o, err_o, mis_o, req_done, timed_out);
      check($sformatf("v%0d_done_seen", i), 32'(timed_out), 32'd0);
      check($sformatf("v%0d_stall", i), 32'(stall_n), 32'(vecs[i].exp_stall));
      check($sformatf("v%0d_req_cycles", i), 32'(req_n), vecs[i].exp_req ? 32'd1 : 32'd0);
      check($sformatf("v%0d_data", i), data_o, vecs[i].exp_data);
      check($sformatf("v%0d_err", i), 32'(err_o), 32'(vecs[i].exp_err));
      check($sformatf("v%0d_misalign", i), 32'(mis_o), 32'(vecs[i].exp_mis));
      check($sformatf("v%0d_req_in_done", i), 32'(req_done), 32'd0);
      if (vecs[i].exp_req) begin
        check($sformatf("v%0d_be", i), 32'(be_o), 32'(vecs[i].exp_be));
        check($sformatf("v%0d_addr", i), addr_o, vecs[i].exp_addr);
        if (vecs[i].we) check($sformatf("v%0d_wdata", i), wdata_o, vecs[i].exp_wdata);
      end
    end

    // Grant held off for 3 cycles: request stays up with stable attributes
    run_txn(1'b0, LDST_W, 32'h400, 32'h0, 32'h0BADF00D, 3, 1'b1,
            stall_n, req_n, stable, be_o, addr_o, wdata_o, data_o, err_o, mis_o, req_done, timed_out);
    check("gntdly_stall", 32'(stall_n), 32'd6);
    check("gntdly_req_cycles", 32'(req_n), 32'd4);
    check("gntdly_stable", 32'(stable), 32'd1);
    check("gntdly_addr", addr_o, 32'h400);
    check("gntdly_data", data_o, 32'h0BADF00D);

    // Granted but never answered: timeout after 8 REQ/WAIT cycles
    run_txn(1'b0, LDST_W, 32'h500, 32'h0, 32'h0, 0, 1'b0,
            stall_n, req_n, stable, be_o, addr_o, wdata_o, data_o, err_o, mis_o, req_done, timed_out);
    check("to_wait_done_seen", 32'(timed_out), 32'd0);
    check("to_wait_stall", 32'(stall_n), 32'd9);
    check("to_wait_err", 32'(err_o), 32'd1);
    check("to_wait_data", data_o, 32'd0);

    // Never granted: timeout in REQ, request dropped
    run_txn(1'b0, LDST_W, 32'h500, 32'h0, 32'h0, 100, 1'b1,
            stall_n, req_n, stable, be_o, addr_o, wdata_o, data_o, err_o, mis_o, req_done, timed_out);
    check("to_req_stall", 32'(stall_n), 32'd9);
    check("to_req_req_cycles", 32'(req_n), 32'd8);
    check("to_req_err", 32'(err_o), 32'd1);
    check("to_req_req_in_done", 32'(req_done), 32'd0);

    // Normal load after an error clears the error flag
    run_txn(1'b0, LDST_W, 32'h600, 32'h0, 32'h55AA55AA, 0, 1'b1,
            stall_n, req_n, stable, be_o, addr_o, wdata_o, data_o, err_o, mis_o, req_done, timed_out);
    check("post_err_data", data_o, 32'h55AA55AA);
    check("post_err_err", 32'(err_o), 32'd0);

    // Reset while waiting for the response; the late response is ignored
    @(posedge clk); #1;
    core_bus.lsu_req  = 1'b1;
    core_bus.lsu_we   = 1'b0;
    core_bus.lsu_size = LDST_W;
    core_bus.lsu_addr = 32'h700;
    @(negedge clk);                   // IDLE
    @(negedge clk);                   // REQ
    check("rstwait_req", 32'(mem_bus.data_req), 32'd1);
    mem_bus.data_gnt = 1'b1;
    @(negedge clk);                   // WAIT
    mem_bus.data_gnt = 1'b0;
    check("rstwait_in_wait", {30'd0, mem_bus.data_req, core_bus.core_stall}, 32'd1);
    arstn = 1'b0;
    core_bus.lsu_req = 1'b0;
    @(negedge clk);
    arstn = 1'b1;
    check("rstwait_stall", 32'(core_bus.core_stall), 32'd0);
    mem_bus.data_rvalid = 1'b1;
    mem_bus.data_rdata  = 32'h12345678;
    @(negedge clk);
    mem_bus.data_rvalid = 1'b0;
    check("rstwait_data", core_bus.lsu_data, 32'd0);
    check("rstwait_err", 32'(core_bus.lsu_err), 32'd0);
    check("rstwait_data_req", 32'(mem_bus.data_req), 32'd0);

    // Unit is back in IDLE: a fresh load takes the minimum 3 stall cycles
    run_txn(1'b0, LDST_HU, 32'h702, 32'h0, 32'hBEEF0001, 0, 1'b1,
            stall_n, req_n, stable, be_o, addr_o, wdata_o, data_o, err_o, mis_o, req_done, timed_out);
    check("after_rst_stall", 32'(stall_n), 32'd3);
    check("after_rst_data", data_o, 32'h0000BEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
